// File: rtl/se_pkg.sv
// Shared types and defaults for the SE-block multiplier scheduler.
// Build option: SE_MUL_TIMEOUT_EN (see se_mul_scheduler.sv).
package se_pkg;

    localparam int DEF_BITSIZE       = 14;
    localparam int DEF_NUM_INSTANCES = 32;
    localparam int DEF_CH_W          = 10;
    localparam int DEF_ADDR_W        = 5;
    localparam int DEF_TIMEOUT       = 64;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } state_e;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/se_lane_mask_gen.sv
// Thermometer lane mask: bit i is set when lane i still holds a live channel
// of the current tile (i < rem); saturates to all-ones for full tiles.
module se_lane_mask_gen
    import se_pkg::*;
#(
    parameter int NUM_INSTANCES = DEF_NUM_INSTANCES,
    parameter int REM_W         = DEF_CH_W + 1
) (
    input  logic [REM_W-1:0]         rem,
    output logic [NUM_INSTANCES-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_INSTANCES; i++) begin
            mask[i] = (int'(rem) > i);
        end
    end

endmodule

// File: rtl/se_mul_scheduler.sv
// Tile sequencer for the SE-block multiplier array: fetch, capture, issue, wait, write back.
// Build option: define SE_MUL_TIMEOUT_EN to bound WAIT with a watchdog and a sticky err flag.
module se_mul_scheduler
    import se_pkg::*;
#(
    parameter int bitsize       = DEF_BITSIZE,
    parameter int NUM_INSTANCES = DEF_NUM_INSTANCES,
    parameter int CH_W          = DEF_CH_W,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [CH_W-1:0]                   cfg_num_ch,
    output logic                              busy,
    output logic                              done,
    output logic                              rd_en,
    output logic [ADDR_W-1:0]                 rd_addr,
    input  logic [bitsize*NUM_INSTANCES-1:0]  rd_data,
    input  logic [bitsize*NUM_INSTANCES-1:0]  rd_weights,
    output logic [bitsize*NUM_INSTANCES-1:0]  mul_a,
    output logic [bitsize*NUM_INSTANCES-1:0]  mul_b,
    output logic                              start_flag,
    input  logic                              mul_valid,
    output logic                              wr_en,
    output logic [ADDR_W-1:0]                 wr_addr,
    output logic [NUM_INSTANCES-1:0]          wr_mask,
    output logic                              err
);

    localparam int LANE_W = bitsize * NUM_INSTANCES;
    localparam int REM_W  = CH_W + 1;

    state_e                   state_q, state_d;
    logic [CH_W-1:0]          num_ch_q, num_ch_d;
    logic [CH_W-1:0]          tiles_q, tiles_d;
    logic [CH_W-1:0]          tile_q, tile_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
    logic [LANE_W-1:0]        mul_a_q, mul_a_d;
    logic [LANE_W-1:0]        mul_b_q, mul_b_d;
    logic                     start_flag_q, start_flag_d;
    logic                     wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
    logic [NUM_INSTANCES-1:0] wr_mask_q, wr_mask_d;

    logic                     accept;
    logic [REM_W-1:0]         rem;
    logic [NUM_INSTANCES-1:0] lane_mask;

`ifdef SE_MUL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
`endif

    assign accept = (state_q == IDLE) && start && !busy_q;
    assign rem    = REM_W'(num_ch_q) - (REM_W'(tile_q) * REM_W'(NUM_INSTANCES));

    se_lane_mask_gen #(
        .NUM_INSTANCES(NUM_INSTANCES),
        .REM_W        (REM_W)
    ) u_mask (
        .rem (rem),
        .mask(lane_mask)
    );

    // busy stays up through the done pulse and clears the cycle after it
    always_comb begin
        state_d   = state_q;
        num_ch_d  = num_ch_q;
        tiles_d   = tiles_q;
        tile_d    = tile_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        wr_mask_d = wr_mask_q;
`ifdef SE_MUL_TIMEOUT_EN
        wait_cnt_d = '0;
        err_d      = err_q;
`endif
        if (done_q) begin
            busy_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    num_ch_d = cfg_num_ch;
                    tiles_d  = CH_W'(ceil_div(32'(cfg_num_ch), NUM_INSTANCES));
                    tile_d   = '0;
                    busy_d   = 1'b1;
                    state_d  = (cfg_num_ch == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                mul_a_d   = rd_data;
                wr_mask_d = lane_mask;
                for (int i = 0; i < NUM_INSTANCES; i++) begin
                    mul_b_d[i*bitsize +: bitsize] =
                        lane_mask[i] ? rd_weights[i*bitsize +: bitsize] : '0;
                end
                state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mul_valid) begin
                    state_d = WRITE;
                end
`ifdef SE_MUL_TIMEOUT_EN
                else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            WRITE: begin
                if (tile_q == tiles_q - CH_W'(1)) begin
                    state_d = DONE;
                end else begin
                    tile_d  = tile_q + CH_W'(1);
                    state_d = FETCH;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_en_d      = (state_d == FETCH);
        rd_addr_d    = (state_d == FETCH) ? ADDR_W'(tile_d) : rd_addr_q;
        start_flag_d = (state_d == ISSUE);
        wr_en_d      = (state_d == WRITE);
        wr_addr_d    = (state_d == WRITE) ? ADDR_W'(tile_d) : wr_addr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            num_ch_q     <= '0;
            tiles_q      <= '0;
            tile_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            start_flag_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_mask_q    <= '0;
`ifdef SE_MUL_TIMEOUT_EN
            wait_cnt_q   <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            num_ch_q     <= num_ch_d;
            tiles_q      <= tiles_d;
            tile_q       <= tile_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            start_flag_q <= start_flag_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_mask_q    <= wr_mask_d;
`ifdef SE_MUL_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign start_flag = start_flag_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_mask    = wr_mask_q;
`ifdef SE_MUL_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

    // Jobs needing more tiles than the buffer address space are illegal
    a_tile_range: assert property (@(posedge clk) disable iff (!rst)
        accept |-> (ceil_div(32'(cfg_num_ch), NUM_INSTANCES) <= (32'd1 << ADDR_W)));

endmodule

// File: tb/tb_se_mul_scheduler.sv
// Directed testbench for se_mul_scheduler with a small array/buffer model.
module tb_se_mul_scheduler;

    localparam int BS     = 14;
    localparam int NI     = 32;
    localparam int CH_W   = 10;
    localparam int ADDR_W = 5;
    localparam int LW     = BS * NI;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CH_W-1:0]   cfg_num_ch;
    logic              busy, done, rd_en, start_flag, mul_valid, wr_en, err;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [LW-1:0]     rd_data, rd_weights, mul_a, mul_b;
    logic [NI-1:0]     wr_mask;

    int vectors     = 0;
    int miscompares = 0;

    int cyc, cyc_rd, cyc_sf, cyc_wr, cyc_done, cyc_busy, done_at;
    int lat, cd, sf_age, inject_ch;
    bit valid_en, spurious_en;

    logic [ADDR_W-1:0] rd_log[$];
    logic [ADDR_W-1:0] wr_log[$];
    logic [NI-1:0]     mask_log[$];
    logic [LW-1:0]     mula_log[$];
    logic [LW-1:0]     mulb_log[$];

    always #5 clk = ~clk;

    se_mul_scheduler #(
        .bitsize(BS), .NUM_INSTANCES(NI), .CH_W(CH_W), .ADDR_W(ADDR_W), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_ch(cfg_num_ch),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_weights(rd_weights), .mul_a(mul_a), .mul_b(mul_b),
        .start_flag(start_flag), .mul_valid(mul_valid), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_mask(wr_mask), .err(err)
    );

    function automatic logic [LW-1:0] act_tile(input int t);
        logic [LW-1:0] v;
        for (int i = 0; i < NI; i++) v[i*BS +: BS] = BS'(14'h0155 + t * 37 + i * 3);
        return v;
    endfunction

    function automatic logic [LW-1:0] wt_tile(input int t);
        logic [LW-1:0] v;
        for (int i = 0; i < NI; i++) v[i*BS +: BS] = BS'(14'h3F00 - t * 11 - i * 5);
        return v;
    endfunction

    task automatic clear_logs();
        cyc = 0; cyc_rd = 0; cyc_sf = 0; cyc_wr = 0; cyc_done = 0; cyc_busy = 0;
        done_at = -1; cd = 0; sf_age = 0;
        rd_log.delete(); wr_log.delete(); mask_log.delete();
        mula_log.delete(); mulb_log.delete();
    endtask

    // Called at a falling edge; start is sampled on the next rising edge
    task automatic launch(input int nch);
        clear_logs();
        cfg_num_ch = CH_W'(nch);
        start      = 1'b1;
    endtask

    // Observes outputs each falling edge and plays buffer + array behaviour
    task automatic run_cycles(input int n, input int stop_sf);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            mul_valid = 1'b0;
            if (busy) cyc_busy++;
            if (done) begin cyc_done++; if (done_at < 0) done_at = cyc; end
            if (rd_en) begin
                cyc_rd++;
                rd_log.push_back(rd_addr);
                rd_data    = act_tile(int'(rd_addr));
                rd_weights = wt_tile(int'(rd_addr));
                if (spurious_en) mul_valid = 1'b1;
            end
            if (wr_en) begin
                cyc_wr++;
                wr_log.push_back(wr_addr);
                mask_log.push_back(wr_mask);
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) mul_valid = valid_en;
            end
            if (start_flag) begin
                cyc_sf++;
                mula_log.push_back(mul_a);
                mulb_log.push_back(mul_b);
                cd = lat;
                sf_age = 0;
            end else begin
                sf_age++;
            end
            start = 1'b0;
            if (inject_ch >= 0 && cyc_sf == 1 && sf_age == 1) begin
                start      = 1'b1;
                cfg_num_ch = CH_W'(inject_ch);
                inject_ch  = -1;
            end
            if (stop_sf > 0 && cyc_sf >= stop_sf) break;
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({busy, done, rd_en, rd_addr, start_flag, wr_en, wr_addr, wr_mask, err} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl got %h want 0",
                     {busy, done, rd_en, rd_addr, start_flag, wr_en, wr_addr, wr_mask, err});
        end
        vectors++;
        if ({mul_a, mul_b} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mul got a=%h b=%h want 0", mul_a, mul_b);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_two_full_tiles();
        lat = 2;
        launch(64);
        run_cycles(20, 0);
        vectors++;
        if (rd_log.size() != 2 || rd_log[0] !== 5'd0 || rd_log[1] !== 5'd1) begin
            miscompares++;
            $display("[TB] FAIL full_rd_addr got n=%0d want addrs 0,1", rd_log.size());
        end
        vectors++;
        if (cyc_sf != 2) begin
            miscompares++;
            $display("[TB] FAIL full_start_flag got %0d want 2", cyc_sf);
        end
        vectors++;
        if (wr_log.size() != 2 || wr_log[0] !== 5'd0 || wr_log[1] !== 5'd1 ||
            mask_log[0] !== 32'hFFFF_FFFF || mask_log[1] !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("[TB] FAIL full_write got n=%0d want 2 writes addr 0,1 mask ffffffff", wr_log.size());
        end
        vectors++;
        if (cyc_done != 1 || done_at != 14) begin
            miscompares++;
            $display("[TB] FAIL full_done got count=%0d at=%0d want 1 at 14", cyc_done, done_at);
        end
        vectors++;
        if (cyc_busy != 14 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_busy got cycles=%0d now=%b want 14 and 0", cyc_busy, busy);
        end
        vectors++;
        if (mula_log[1] !== act_tile(1) || mulb_log[0] !== wt_tile(0)) begin
            miscompares++;
            $display("[TB] FAIL full_operands got a1=%h want %h", mula_log[1], act_tile(1));
        end
    endtask

    task automatic test_partial_tile();
        logic [LW-1:0] exp_b;
        lat = 3;
        spurious_en = 1'b1;
        launch(40);
        run_cycles(30, 0);
        spurious_en = 1'b0;
        exp_b = wt_tile(1) & {{(24*BS){1'b0}}, {(8*BS){1'b1}}};
        vectors++;
        if (mask_log.size() != 2 || mask_log[0] !== 32'hFFFF_FFFF || mask_log[1] !== 32'h0000_00FF) begin
            miscompares++;
            $display("[TB] FAIL part_mask got n=%0d m1=%h want ffffffff,000000ff",
                     mask_log.size(), mask_log[1]);
        end
        vectors++;
        if (mulb_log[1] !== exp_b) begin
            miscompares++;
            $display("[TB] FAIL part_mul_b got %h want %h", mulb_log[1], exp_b);
        end
        vectors++;
        if (mula_log[1] !== act_tile(1)) begin
            miscompares++;
            $display("[TB] FAIL part_mul_a got %h want %h", mula_log[1], act_tile(1));
        end
        vectors++;
        if (cyc_wr != 2 || cyc_done != 1 || cyc_sf != 2) begin
            miscompares++;
            $display("[TB] FAIL part_counts got wr=%0d done=%0d sf=%0d want 2,1,2", cyc_wr, cyc_done, cyc_sf);
        end
    endtask

    task automatic test_zero_channels();
        launch(0);
        run_cycles(6, 0);
        vectors++;
        if (cyc_rd != 0 || cyc_sf != 0 || cyc_wr != 0) begin
            miscompares++;
            $display("[TB] FAIL zero_activity got rd=%0d sf=%0d wr=%0d want 0,0,0", cyc_rd, cyc_sf, cyc_wr);
        end
        vectors++;
        if (cyc_done != 1 || done_at != 2) begin
            miscompares++;
            $display("[TB] FAIL zero_done got count=%0d at=%0d want 1 at 2", cyc_done, done_at);
        end
        vectors++;
        if (cyc_busy != 2) begin
            miscompares++;
            $display("[TB] FAIL zero_busy got %0d want 2", cyc_busy);
        end
    endtask

    task automatic test_back_to_back();
        lat = 4;
        inject_ch = 96;
        launch(64);
        run_cycles(40, 0);
        inject_ch = -1;
        vectors++;
        if (cyc_wr != 2 || wr_log[0] !== 5'd0 || wr_log[1] !== 5'd1) begin
            miscompares++;
            $display("[TB] FAIL restart_writes got %0d want 2 at addr 0,1", cyc_wr);
        end
        vectors++;
        if (cyc_rd != 2 || cyc_done != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL restart_job got rd=%0d done=%0d busy=%b want 2,1,0", cyc_rd, cyc_done, busy);
        end
    endtask

    task automatic test_reset_mid_job();
        lat = 6;
        launch(64);
        run_cycles(40, 2);
        run_cycles(1, 0);
        rst = 1'b0;
        #1;
        vectors++;
        if ({busy, done, rd_en, rd_addr, start_flag, wr_en, wr_addr, wr_mask, err} !== '0 ||
            {mul_a, mul_b} !== '0) begin
            miscompares++;
            $display("[TB] FAIL midreset_outputs got busy=%b mask=%h a=%h", busy, wr_mask, mul_a);
        end
        run_cycles(3, 0);
        vectors++;
        if (cyc_done != 0 || cyc_wr != 1) begin
            miscompares++;
            $display("[TB] FAIL midreset_no_done got done=%0d wr=%0d want 0,1", cyc_done, cyc_wr);
        end
        rst = 1'b1;
        lat = 2;
        launch(32);
        run_cycles(20, 0);
        vectors++;
        if (rd_log.size() != 1 || rd_log[0] !== 5'd0 || wr_log.size() != 1 || wr_log[0] !== 5'd0 ||
            mask_log[0] !== 32'hFFFF_FFFF || cyc_done != 1) begin
            miscompares++;
            $display("[TB] FAIL midreset_rerun got rd=%0d wr=%0d done=%0d want 1,1,1",
                     rd_log.size(), wr_log.size(), cyc_done);
        end
        vectors++;
        if (mulb_log[0] !== wt_tile(0)) begin
            miscompares++;
            $display("[TB] FAIL midreset_mul_b got %h want %h", mulb_log[0], wt_tile(0));
        end
    endtask

    task automatic test_max_channels();
        lat = 1;
        launch(1023);
        run_cycles(200, 0);
        vectors++;
        if (cyc_wr != 32 || wr_log[31] !== 5'd31 || rd_log[31] !== 5'd31) begin
            miscompares++;
            $display("[TB] FAIL max_tiles got wr=%0d last=%0d want 32 last 31", cyc_wr, wr_log[31]);
        end
        vectors++;
        if (mask_log[31] !== 32'h7FFF_FFFF || mask_log[30] !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("[TB] FAIL max_mask got %h want 7fffffff", mask_log[31]);
        end
        vectors++;
        if (cyc_done != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL max_done got %0d busy=%b want 1,0", cyc_done, busy);
        end
    endtask

    task automatic test_err_flag();
        lat = 2;
        valid_en = 1'b0;
        launch(64);
`ifdef SE_MUL_TIMEOUT_EN
        run_cycles(90, 0);
        vectors++;
        if (err !== 1'b1 || cyc_wr != 0 || cyc_done != 1 || done_at != 69 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout got err=%b wr=%0d done=%0d at=%0d want 1,0,1 at 69",
                     err, cyc_wr, cyc_done, done_at);
        end
        run_cycles(5, 0);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timeout_sticky got %b want 1", err);
        end
`else
        run_cycles(100, 0);
        vectors++;
        if (err !== 1'b0 || cyc_wr != 0 || cyc_done != 0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wait_unbounded got err=%b wr=%0d done=%0d busy=%b want 0,0,0,1",
                     err, cyc_wr, cyc_done, busy);
        end
`endif
        rst = 1'b0;
        #1;
        vectors++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_reset got err=%b busy=%b want 0,0", err, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        valid_en = 1'b1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; cfg_num_ch = '0; mul_valid = 1'b0;
        rd_data = '0; rd_weights = '0;
        lat = 2; valid_en = 1'b1; spurious_en = 1'b0; inject_ch = -1;
        clear_logs();
        test_reset();
        test_two_full_tiles();
        test_partial_tile();
        test_zero_channels();
        test_back_to_back();
        test_reset_mid_job();
        test_max_channels();
        test_err_flag();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
